// File: rtl/demux16_deser.sv
// demux16_deser: receive end of the 16:1 select-scan serial path.
// Steers one valid bit per cycle into a 16-slot word and strobes it out.
module demux16_deser (
    input  logic        clk,
    input  logic        rst,
    input  logic        in,
    input  logic        in_valid,
    input  logic        sync,
    output logic [0:15] out,
    output logic        out_valid,
    output logic [0:3]  sel,
    output logic        frame_err
);

    logic [0:15] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage     <= '0;
            sel       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (in_valid) begin
                if (sync) begin
                    // a sync restarts the frame; any partial word is dropped
                    stage[0]  <= in;
                    sel       <= 4'd1;
                    frame_err <= (sel != 4'd0);
                end else begin
                    stage[sel] <= in;
                    sel        <= sel + 4'd1;
                    if (sel == 4'd15) begin
                        out       <= {stage[0:14], in};
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
